// File: rtl/maze_pkg.sv
// Shared types and sprite tables for maze actors.
package maze_pkg;

  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    DIR_L    = 3'd1,
    DIR_U    = 3'd2,
    DIR_R    = 3'd3,
    DIR_D    = 3'd4
  } dir_t;

  localparam logic [3:0] SPR_CLOSED  = 4'd8;
  localparam int         ANIM_PHASES = 9;

  // Legal-move lookup: avail bit order is [0]L [1]U [2]R [3]D.
  function automatic logic dir_ok(input logic [2:0] d, input logic [3:0] a);
    case (d)
      DIR_L:   return a[0];
      DIR_U:   return a[1];
      DIR_R:   return a[2];
      DIR_D:   return a[3];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] spr_wide(input logic [2:0] d);
    case (d)
      DIR_L:   return 4'd0;
      DIR_U:   return 4'd1;
      DIR_R:   return 4'd4;
      DIR_D:   return 4'd5;
      default: return SPR_CLOSED;
    endcase
  endfunction

  function automatic logic [3:0] spr_half(input logic [2:0] d);
    case (d)
      DIR_L:   return 4'd2;
      DIR_U:   return 4'd3;
      DIR_R:   return 4'd6;
      DIR_D:   return 4'd7;
      default: return SPR_CLOSED;
    endcase
  endfunction

endpackage

// File: rtl/actor_anim.sv
// Mouth animation: 9-phase counter paced by ANIM_DIV moving ticks, mapped to sprite index.
module actor_anim
  import maze_pkg::*;
#(
  parameter int ANIM_DIV = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       step_i,
  input  logic       turn_i,
  input  logic [2:0] dir_i,
  output logic [3:0] sprite_o
);

  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [3:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      phase_d = 4'd0;
      cnt_d   = '0;
    end else if (step_i) begin
      // A fresh turn restarts the mouth half-open.
      if (turn_i) begin
        phase_d = 4'd2;
        cnt_d   = '0;
      end else if (cnt_q == CW'(ANIM_DIV - 1)) begin
        cnt_d   = '0;
        phase_d = (phase_q == 4'(ANIM_PHASES - 1)) ? 4'd0 : phase_q + 4'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= 4'd0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    sprite_o = SPR_CLOSED;
    if (dir_i != DIR_NONE) begin
      case (phase_q)
        4'd2, 4'd3, 4'd7, 4'd8: sprite_o = spr_half(dir_i);
        4'd4, 4'd5, 4'd6:       sprite_o = spr_wide(dir_i);
        default:                sprite_o = SPR_CLOSED;
      endcase
    end
  end

endmodule

// File: rtl/maze_actor_ctrl.sv
// Per-frame movement controller for one maze actor: buffered turns, fractional speed, hit box.
// Optional tunnel wrap is enabled with MAZE_TUNNEL_WRAP_EN.
module maze_actor_ctrl
  import maze_pkg::*;
#(
  parameter int W        = 10,
  parameter int START_X  = 228,
  parameter int START_Y  = 336,
  parameter int SPRITE_W = 24,
  parameter int SPRITE_H = 24,
  parameter int Y_OFS    = 6,
  parameter int SPEED_Q4 = 16,
  parameter int ANIM_DIV = 1,
  parameter int TUN_LO   = 0,
  parameter int TUN_HI   = 432
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         frame_tick,
  input  logic         restart,
  input  logic [2:0]   dir_req,
  input  logic [3:0]   avail_dir,
  input  logic [W-1:0] DrawX,
  input  logic [W-1:0] DrawY,
  output logic         is_actor,
  output logic [3:0]   sprite_idx,
  output logic [W-1:0] posX,
  output logic [W-1:0] posY,
  output logic [2:0]   cur_dir
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] px_q, px_d, py_q, py_d;
  logic [2:0]   cur_q, cur_d, pend_q, pend_d, eff;
  logic [3:0]   acc_q, acc_d;
  logic [4:0]   sum;
  logic         turn, moving;

  always_comb begin
    px_d   = px_q;
    py_d   = py_q;
    cur_d  = cur_q;
    pend_d = pend_q;
    acc_d  = acc_q;
    eff    = cur_q;
    turn   = 1'b0;
    moving = 1'b0;
    sum    = {1'b0, acc_q} + 5'(SPEED_Q4);
    if (frame_tick) begin
      if (pend_q != DIR_NONE && pend_q != cur_q && dir_ok(pend_q, avail_dir)) begin
        turn   = 1'b1;
        eff    = pend_q;
        pend_d = DIR_NONE;
      end
`ifdef MAZE_TUNNEL_WRAP_EN
      // Tunnel jump overrides the maze walls and leaves the sub-pixel phase intact.
      if (eff == DIR_L && px_q == W'(TUN_LO)) begin
        px_d   = W'(TUN_HI);
        cur_d  = eff;
        moving = 1'b1;
      end else if (eff == DIR_R && px_q == W'(TUN_HI)) begin
        px_d   = W'(TUN_LO);
        cur_d  = eff;
        moving = 1'b1;
      end else
`endif
      if (eff != DIR_NONE && !dir_ok(eff, avail_dir)) begin
        cur_d = DIR_NONE;
      end else if (eff != DIR_NONE) begin
        moving = 1'b1;
        cur_d  = eff;
        acc_d  = sum[3:0];
        if (sum[4]) begin
          case (eff)
            DIR_L:   px_d = px_q - ONE;
            DIR_U:   py_d = py_q - ONE;
            DIR_R:   px_d = px_q + ONE;
            DIR_D:   py_d = py_q + ONE;
            default: ;
          endcase
        end
      end
    end
    // Requests are latched every cycle; one arriving on a tick waits for the next tick.
    if (dir_req != DIR_NONE) pend_d = dir_req;
    if (restart) begin
      px_d   = W'(START_X);
      py_d   = W'(START_Y);
      cur_d  = DIR_NONE;
      pend_d = DIR_NONE;
      acc_d  = 4'd0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      px_q   <= W'(START_X);
      py_q   <= W'(START_Y);
      cur_q  <= DIR_NONE;
      pend_q <= DIR_NONE;
      acc_q  <= 4'd0;
    end else begin
      px_q   <= px_d;
      py_q   <= py_d;
      cur_q  <= cur_d;
      pend_q <= pend_d;
      acc_q  <= acc_d;
    end
  end

  actor_anim #(.ANIM_DIV(ANIM_DIV)) u_anim (
    .clk_i    (Clk),
    .rst_ni   (Reset_n),
    .clr_i    (restart),
    .step_i   (frame_tick & moving),
    .turn_i   (turn),
    .dir_i    (cur_q),
    .sprite_o (sprite_idx)
  );

  logic [W:0] dx, dy, x0, x1, y0, y1;

  always_comb begin
    dx = {1'b0, DrawX};
    dy = {1'b0, DrawY};
    x0 = {1'b0, px_q};
    x1 = x0 + (W+1)'(SPRITE_W);
    y0 = {1'b0, py_q} + (W+1)'(Y_OFS);
    y1 = y0 + (W+1)'(SPRITE_H);
    is_actor = (dx >= x0) && (dx < x1) && (dy >= y0) && (dy < y1);
  end

  assign posX    = px_q;
  assign posY    = py_q;
  assign cur_dir = cur_q;

endmodule

// File: tb/tb_maze_actor_ctrl.sv
// Scoreboard bench for maze_actor_ctrl; build with MAZE_TUNNEL_WRAP_EN to cover the tunnel.
module tb_maze_actor_ctrl;

  localparam int W = 10, SX = 228, SY = 336, SPW = 24, SPH = 24, YO = 6;
  localparam int SPEED = 8, ADIV = 1, TLO = 0, THI = 432;

  logic         Clk = 1'b0, Reset_n = 1'b0, frame_tick = 1'b0, restart = 1'b0;
  logic [2:0]   dir_req = '0;
  logic [3:0]   avail_dir = '0;
  logic [W-1:0] DrawX = '0, DrawY = '0;
  logic         is_actor;
  logic [3:0]   sprite_idx;
  logic [W-1:0] posX, posY;
  logic [2:0]   cur_dir;

  maze_actor_ctrl #(
    .W(W), .START_X(SX), .START_Y(SY), .SPRITE_W(SPW), .SPRITE_H(SPH), .Y_OFS(YO),
    .SPEED_Q4(SPEED), .ANIM_DIV(ADIV), .TUN_LO(TLO), .TUN_HI(THI)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .restart(restart),
    .dir_req(dir_req), .avail_dir(avail_dir), .DrawX(DrawX), .DrawY(DrawY),
    .is_actor(is_actor), .sprite_idx(sprite_idx), .posX(posX), .posY(posY), .cur_dir(cur_dir)
  );

  always #5 Clk = ~Clk;

  typedef struct { int px; int py; int cur; int spr; } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_err = 0;
  int m_px, m_py, m_cur, m_pend, m_acc, m_phase, m_cnt;
  int spr_w[5] = '{8, 0, 1, 4, 5};
  int spr_h[5] = '{8, 2, 3, 6, 7};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_px = SX; m_py = SY; m_cur = 0; m_pend = 0; m_acc = 0; m_phase = 0; m_cnt = 0;
  endtask

  function automatic int model_spr();
    if (m_cur == 0 || m_phase < 2) return 8;
    if (m_phase >= 4 && m_phase <= 6) return spr_w[m_cur];
    return spr_h[m_cur];
  endfunction

  function automatic bit model_hit(input int x, input int y);
    return x >= m_px && x < m_px + SPW && y >= m_py + YO && y < m_py + YO + SPH;
  endfunction

  task automatic model_step(input bit tk, input bit rs, input int d, input logic [3:0] av);
    int eff, npend, s;
    bit mv, tr, wrapped;
    if (rs) begin model_reset(); return; end
    eff = m_cur; npend = m_pend; mv = 0; tr = 0; wrapped = 0;
    if (tk) begin
      if (m_pend != 0 && m_pend != m_cur && av[m_pend-1]) begin
        tr = 1; eff = m_pend; npend = 0;
      end
`ifdef MAZE_TUNNEL_WRAP_EN
      if (eff == 1 && m_px == TLO) begin m_px = THI; m_cur = eff; mv = 1; wrapped = 1; end
      else if (eff == 3 && m_px == THI) begin m_px = TLO; m_cur = eff; mv = 1; wrapped = 1; end
`endif
      if (!wrapped && eff != 0) begin
        if (!av[eff-1]) m_cur = 0;
        else begin
          mv = 1; m_cur = eff; s = m_acc + SPEED; m_acc = s % 16;
          if (s >= 16) begin
            if (eff == 1) m_px--; else if (eff == 2) m_py--;
            else if (eff == 3) m_px++; else m_py++;
          end
        end
      end
      if (mv) begin
        if (tr) begin m_phase = 2; m_cnt = 0; end
        else begin
          m_cnt++;
          if (m_cnt == ADIV) begin m_cnt = 0; m_phase = (m_phase + 1) % 9; end
        end
      end
    end
    if (d != 0) npend = d;
    m_pend = npend;
  endtask

  task automatic cyc(input bit tk, input bit rs, input logic [2:0] d, input logic [3:0] av);
    exp_t e, g;
    @(negedge Clk);
    frame_tick = tk; restart = rs; dir_req = d; avail_dir = av;
    model_step(tk, rs, int'(d), av);
    e.px = m_px; e.py = m_py; e.cur = m_cur; e.spr = model_spr();
    sb.push_back(e);
    @(posedge Clk); #1;
    if (sb.size() == 0) chk("sb_empty", 0, 1);
    else begin
      g = sb.pop_front();
      chk("posX", posX, g.px);
      chk("posY", posY, g.py);
      chk("cur_dir", cur_dir, g.cur);
      chk("sprite", sprite_idx, g.spr);
    end
    frame_tick = 0; restart = 0; dir_req = 0;
  endtask

  task automatic hit_probe(input string tag, input int x, input int y);
    DrawX = W'(x); DrawY = W'(y); #1;
    chk(tag, is_actor, model_hit(x, y));
  endtask

  initial begin
    int y0, n;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_posX", posX, SX);
    chk("rst_posY", posY, SY);
    chk("rst_dir", cur_dir, 0);
    chk("rst_spr", sprite_idx, 8);
    @(negedge Clk); Reset_n = 1'b1;

    hit_probe("hit_tl", SX, SY + YO);
    hit_probe("hit_br", SX + SPW - 1, SY + YO + SPH - 1);
    hit_probe("hit_xr", SX + SPW, SY + YO);
    hit_probe("hit_xl", SX - 1, SY + YO);
    hit_probe("hit_yt", SX, SY + YO - 1);
    hit_probe("hit_yb", SX, SY + YO + SPH);

    // Turn right from rest at half-pixel speed.
    cyc(0, 0, 3'd3, 4'b0000);
    repeat (4) cyc(1, 0, 3'd0, 4'b0100);
    chk("t2_posX", posX, 230);
    chk("t2_dir", cur_dir, 3);
    chk("t2_spr", sprite_idx, 4);

    // Asynchronous reset in the middle of a move.
    cyc(1, 0, 3'd0, 4'b0100);
    @(posedge Clk); #2;
    Reset_n = 1'b0; #1;
    chk("arst_posX", posX, SX);
    chk("arst_posY", posY, SY);
    chk("arst_dir", cur_dir, 0);
    chk("arst_spr", sprite_idx, 8);
    model_reset();
    @(negedge Clk); Reset_n = 1'b1;

    // Buffered upward turn that waits for the opening.
    cyc(0, 0, 3'd1, 4'b0000);
    repeat (2) cyc(1, 0, 3'd0, 4'b0001);
    cyc(0, 0, 3'd2, 4'b0000);
    repeat (3) cyc(1, 0, 3'd0, 4'b0001);
    chk("t3_hold", cur_dir, 1);
    y0 = int'(posY);
    cyc(1, 0, 3'd0, 4'b0011);
    chk("t3_turn", cur_dir, 2);
    chk("t3_posY", posY, y0 - 1);

    // Wall ahead while moving down; pending request must survive the halt.
    cyc(0, 0, 3'd4, 4'b0000);
    repeat (3) cyc(1, 0, 3'd0, 4'b1000);
    cyc(0, 0, 3'd3, 4'b0000);
    cyc(1, 0, 3'd0, 4'b0000);
    chk("t4_halt", cur_dir, 0);
    chk("t4_spr", sprite_idx, 8);
    cyc(1, 0, 3'd0, 4'b0000);
    cyc(1, 0, 3'd0, 4'b0100);
    chk("t4_pend", cur_dir, 3);

    // Restart beats a simultaneous frame tick.
    cyc(1, 1, 3'd3, 4'b0100);
    chk("t5_posX", posX, SX);
    chk("t5_dir", cur_dir, 0);

    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 1'b0, 3'($urandom_range(0, 4)), 4'($urandom));
      cyc(1'b1, 1'b0, 3'($urandom_range(0, 4)), 4'($urandom));
    end

    // Run left to the tunnel edge, then tick with no legal moves.
    cyc(0, 1, 3'd0, 4'b0000);
    cyc(0, 0, 3'd1, 4'b0000);
    n = 0;
    while (m_px != TLO && n < 1000) begin
      cyc(1, 0, 3'd0, 4'b0001);
      n++;
    end
    chk("t6_reach", posX, TLO);
    cyc(1, 0, 3'd0, 4'b0000);
`ifdef MAZE_TUNNEL_WRAP_EN
    chk("t6_wrapX", posX, THI);
    chk("t6_wrapdir", cur_dir, 1);
`else
    chk("t6_haltX", posX, TLO);
    chk("t6_haltdir", cur_dir, 0);
`endif
    hit_probe("hit_end_in", m_px + 3, m_py + YO + 2);
    hit_probe("hit_end_out", m_px + SPW + 1, m_py + YO + 2);

    chk("sb_left", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
